// File: rtl/nor_result_checker.sv
// Checking stage for an n-bit bitwise NOR gate. It recomputes ~(A|B) over a
// 2-stage pipeline and counts checked and failing vectors. It also reports a
// sticky pass/fail verdict once the last vector of a run has drained.
module nor_result_checker #(
    parameter int n     = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [n-1:0]     A,
    input  logic [n-1:0]     B,
    input  logic [n-1:0]     F,
    input  logic             last,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             first_fail_vld,
    output logic [CNT_W-1:0] first_fail_idx
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_clear;
    logic             w_mis;
    logic             w_vec_sat;

    logic             r_s1_vld;
    logic             r_s1_last;
    logic [n-1:0]     r_a;
    logic [n-1:0]     r_b;
    logic [n-1:0]     r_f;

    logic [CNT_W-1:0] r_vec_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic             r_ff_vld;
    logic [CNT_W-1:0] r_ff_idx;

    assign w_accept  = in_valid && (r_state == S_RUN);
    assign w_mis     = |(r_f ^ ~(r_a | r_b));
    assign w_vec_sat = (r_vec_cnt == CNT_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_clear     = 1'b1;
                end
            end
            S_RUN: begin
                if (w_accept && last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The last vector is in stage 1 and is counted on this edge.
                if (r_s1_vld && r_s1_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_clear     = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Stage 1: capture the accepted triple.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_f       <= '0;
        end else if (w_clear) begin
            r_s1_vld  <= 1'b0;
            r_s1_last <= 1'b0;
        end else begin
            r_s1_vld <= w_accept;
            if (w_accept) begin
                r_s1_last <= last;
                r_a       <= A;
                r_b       <= B;
                r_f       <= F;
            end
        end
    end

    // Stage 2: compare and update the saturating statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec_cnt  <= '0;
            r_fail_cnt <= '0;
            r_ff_vld   <= 1'b0;
            r_ff_idx   <= '0;
        end else if (w_clear) begin
            r_vec_cnt  <= '0;
            r_fail_cnt <= '0;
            r_ff_vld   <= 1'b0;
            r_ff_idx   <= '0;
        end else if (r_s1_vld) begin
            if (!w_vec_sat) begin
                r_vec_cnt <= r_vec_cnt + 1'b1;
            end
            if (w_mis && (r_fail_cnt != CNT_MAX)) begin
                r_fail_cnt <= r_fail_cnt + 1'b1;
            end
            if (w_mis && !r_ff_vld) begin
                r_ff_vld <= 1'b1;
                r_ff_idx <= r_vec_cnt;
            end
        end
    end

    assign in_ready       = (r_state == S_RUN);
    assign busy           = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done           = (r_state == S_DONE);
    assign pass           = done && (r_fail_cnt == '0) && (r_vec_cnt != '0);
    assign vec_cnt        = r_vec_cnt;
    assign fail_cnt       = r_fail_cnt;
    assign first_fail_vld = r_ff_vld;
    assign first_fail_idx = r_ff_idx;

endmodule

// File: tb/tb_nor_result_checker.sv
// Bench for nor_result_checker. It drives directed and randomized runs into a
// wide-counter and a 2-bit-counter instance and checks them against a vector-list model.
module tb_nor_result_checker;

    logic       clk = 1'b0;
    logic       rst;

    logic       start1, in_valid1, last1;
    logic [3:0] a1, b1, f1;
    logic       in_ready1, busy1, done1, pass1, ffv1;
    logic [7:0] vec1, fail1, ffi1;

    logic       start2, in_valid2, last2;
    logic [3:0] a2, b2, f2;
    logic       in_ready2, busy2, done2, pass2, ffv2;
    logic [1:0] vec2, fail2, ffi2;

    int         n_cmp = 0;
    int         n_bad = 0;
    bit         cur_sel = 1'b0;

    logic [3:0] q_a[$];
    logic [3:0] q_b[$];
    logic [3:0] q_f[$];

    logic       o_rdy, o_busy, o_done, o_pass, o_ffv;
    logic [7:0] o_vec, o_fail, o_ffi;

    always #5 clk = ~clk;

    nor_result_checker #(.n(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1), .in_ready(in_ready1),
        .A(a1), .B(b1), .F(f1), .last(last1), .busy(busy1), .done(done1), .pass(pass1),
        .vec_cnt(vec1), .fail_cnt(fail1), .first_fail_vld(ffv1), .first_fail_idx(ffi1)
    );

    nor_result_checker #(.n(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid2), .in_ready(in_ready2),
        .A(a2), .B(b2), .F(f2), .last(last2), .busy(busy2), .done(done2), .pass(pass2),
        .vec_cnt(vec2), .fail_cnt(fail2), .first_fail_vld(ffv2), .first_fail_idx(ffi2)
    );

    assign o_rdy  = cur_sel ? in_ready2 : in_ready1;
    assign o_busy = cur_sel ? busy2 : busy1;
    assign o_done = cur_sel ? done2 : done1;
    assign o_pass = cur_sel ? pass2 : pass1;
    assign o_ffv  = cur_sel ? ffv2 : ffv1;
    assign o_vec  = cur_sel ? {6'b0, vec2} : vec1;
    assign o_fail = cur_sel ? {6'b0, fail2} : fail1;
    assign o_ffi  = cur_sel ? {6'b0, ffi2} : ffi1;

    function automatic logic [3:0] nor4(input logic [3:0] a, input logic [3:0] b);
        return ~(a | b);
    endfunction

    // Expected end-of-run statistics computed directly from the vector list.
    task automatic model(input int max, output int e_vec, output int e_fail,
                         output int e_ffv, output int e_ffi);
        int fails = 0;
        int first = -1;
        for (int i = 0; i < q_a.size(); i++) begin
            if (q_f[i] !== nor4(q_a[i], q_b[i])) begin
                fails++;
                if (first < 0) first = i;
            end
        end
        e_vec  = (q_a.size() > max) ? max : q_a.size();
        e_fail = (fails > max) ? max : fails;
        e_ffv  = (first >= 0) ? 1 : 0;
        e_ffi  = (first < 0) ? 0 : ((first > max) ? max : first);
    endtask

    task automatic drive(input bit v, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] f, input bit l);
        if (!cur_sel) begin
            in_valid1 = v; a1 = a; b1 = b; f1 = f; last1 = l;
        end else begin
            in_valid2 = v; a2 = a; b2 = b; f2 = f; last2 = l;
        end
    endtask

    task automatic set_start(input bit s);
        if (!cur_sel) start1 = s;
        else          start2 = s;
    endtask

    task automatic drive_idle();
        drive(1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
    endtask

    task automatic push_vec(input logic [3:0] a, input logic [3:0] b, input logic [3:0] f);
        q_a.push_back(a);
        q_b.push_back(b);
        q_f.push_back(f);
    endtask

    task automatic clear_q();
        q_a.delete();
        q_b.delete();
        q_f.delete();
    endtask

    // Full run of the queued vectors; a start pulse rides on vector mid_start (ignored in RUN).
    task automatic run_queue(input bit sel, input int gap_pct, input int mid_start, input string name);
        int e_vec, e_fail, e_ffv, e_ffi, k;
        cur_sel = sel;
        pulse_start();
        for (int i = 0; i < q_a.size(); i++) begin
            while ($urandom_range(0, 99) < gap_pct) begin
                drive_idle();
                @(negedge clk);
            end
            n_cmp++;
            if (o_rdy !== 1'b1) begin
                n_bad++;
                $display("FAIL %s in_ready before vec %0d: got %b want 1", name, i, o_rdy);
            end
            drive(1'b1, q_a[i], q_b[i], q_f[i], i == q_a.size() - 1);
            if (i == mid_start) set_start(1'b1);
            @(negedge clk);
            set_start(1'b0);
        end
        drive_idle();
        k = 0;
        while (o_done !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (o_done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s done timeout: got %b want 1", name, o_done);
        end
        model(sel ? 3 : 255, e_vec, e_fail, e_ffv, e_ffi);
        n_cmp++;
        if (o_vec !== 8'(e_vec)) begin
            n_bad++;
            $display("FAIL %s vec_cnt: got %0d want %0d", name, o_vec, e_vec);
        end
        n_cmp++;
        if (o_fail !== 8'(e_fail)) begin
            n_bad++;
            $display("FAIL %s fail_cnt: got %0d want %0d", name, o_fail, e_fail);
        end
        n_cmp++;
        if (o_ffv !== 1'(e_ffv)) begin
            n_bad++;
            $display("FAIL %s first_fail_vld: got %b want %0d", name, o_ffv, e_ffv);
        end
        n_cmp++;
        if (o_ffi !== 8'(e_ffi)) begin
            n_bad++;
            $display("FAIL %s first_fail_idx: got %0d want %0d", name, o_ffi, e_ffi);
        end
        n_cmp++;
        if (o_pass !== 1'(e_fail == 0 && e_vec != 0)) begin
            n_bad++;
            $display("FAIL %s pass: got %b want %0d", name, o_pass, (e_fail == 0 && e_vec != 0));
        end
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy after done: got %b want 0", name, o_busy);
        end
    endtask

    task automatic check_all_zero(input string name);
        n_cmp++;
        if ({o_rdy, o_busy, o_done, o_pass, o_ffv} !== 5'b0 || o_vec !== 8'd0 ||
            o_fail !== 8'd0 || o_ffi !== 8'd0) begin
            n_bad++;
            $display("FAIL %s outputs: got rdy=%b busy=%b done=%b pass=%b ffv=%b vec=%0d fail=%0d ffi=%0d want all 0",
                     name, o_rdy, o_busy, o_done, o_pass, o_ffv, o_vec, o_fail, o_ffi);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start1 = 0; in_valid1 = 0; a1 = 0; b1 = 0; f1 = 0; last1 = 0;
        start2 = 0; in_valid2 = 0; a2 = 0; b2 = 0; f2 = 0; last2 = 0;
        repeat (3) @(negedge clk);
        cur_sel = 1'b0;
        check_all_zero("reset_dut");
        cur_sel = 1'b1;
        check_all_zero("reset_dut2");
        rst = 1'b0;
        @(negedge clk);
        cur_sel = 1'b0;
        check_all_zero("after_reset_dut");
    endtask

    task automatic test_directed();
        clear_q();
        push_vec(4'b1010, 4'b0000, 4'b0101);
        push_vec(4'b1100, 4'b1111, 4'b0000);
        push_vec(4'b0000, 4'b1111, 4'b0000);
        run_queue(1'b0, 0, -1, "all_pass");
        q_f[1] = 4'b0001;
        run_queue(1'b0, 0, -1, "one_fail");
    endtask

    task automatic test_back_to_back();
        clear_q();
        for (int i = 0; i < 4; i++) begin
            logic [3:0] a, b;
            a = 4'($urandom);
            b = 4'($urandom);
            push_vec(a, b, nor4(a, b));
        end
        cur_sel = 1'b0;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, q_a[i], q_b[i], q_f[i], i == 3);
            @(negedge clk);
        end
        drive_idle();
        n_cmp++;
        if (o_rdy !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b1 || o_vec !== 8'd3) begin
            n_bad++;
            $display("FAIL b2b after last accept: got rdy=%b done=%b busy=%b vec=%0d want 0 0 1 3",
                     o_rdy, o_done, o_busy, o_vec);
        end
        @(negedge clk);
        n_cmp++;
        if (o_done !== 1'b1 || o_vec !== 8'd4 || o_pass !== 1'b1 || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b drain: got done=%b vec=%0d pass=%b busy=%b want 1 4 1 0",
                     o_done, o_vec, o_pass, o_busy);
        end
    endtask

    task automatic test_saturation();
        clear_q();
        for (int i = 0; i < 5; i++) begin
            logic [3:0] a, b;
            a = 4'($urandom);
            b = 4'($urandom);
            push_vec(a, b, ~nor4(a, b));
        end
        run_queue(1'b1, 0, -1, "sat5");
        for (int r = 0; r < 6; r++) begin
            clear_q();
            for (int i = 0; i < $urandom_range(1, 8); i++) begin
                logic [3:0] a, b;
                a = 4'($urandom);
                b = 4'($urandom);
                push_vec(a, b, ($urandom_range(0, 99) < 75) ? nor4(a, b) : 4'($urandom));
            end
            run_queue(1'b1, 25, -1, "sat_rand");
        end
    endtask

    task automatic test_mid_reset();
        cur_sel = 1'b0;
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'b0011, 4'b0100, 4'b0000, 1'b0);
            @(negedge clk);
        end
        drive_idle();
        rst = 1'b1;
        #1;
        check_all_zero("mid_run_reset");
        @(negedge clk);
        rst = 1'b0;
        clear_q();
        push_vec(4'b0001, 4'b0010, 4'b1100);
        push_vec(4'b1111, 4'b0000, 4'b0000);
        push_vec(4'b0000, 4'b0000, 4'b1111);
        run_queue(1'b0, 0, -1, "fresh_after_reset");
    endtask

    task automatic test_ignored();
        cur_sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 1'b1);
            @(negedge clk);
        end
        drive_idle();
        n_cmp++;
        if (o_vec !== 8'd3 || o_done !== 1'b1 || o_rdy !== 1'b0 || o_pass !== 1'b1) begin
            n_bad++;
            $display("FAIL valid_in_done: got vec=%0d done=%b rdy=%b pass=%b want 3 1 0 1",
                     o_vec, o_done, o_rdy, o_pass);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 1'b1);
            @(negedge clk);
        end
        drive_idle();
        @(negedge clk);
        check_all_zero("valid_in_idle");
        clear_q();
        for (int i = 0; i < 4; i++) begin
            logic [3:0] a, b;
            a = 4'($urandom);
            b = 4'($urandom);
            push_vec(a, b, (i == 2) ? ~nor4(a, b) : nor4(a, b));
        end
        run_queue(1'b0, 0, 1, "start_in_run");
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            clear_q();
            for (int i = 0; i < $urandom_range(1, 20); i++) begin
                logic [3:0] a, b;
                a = 4'($urandom);
                b = 4'($urandom);
                push_vec(a, b, ($urandom_range(0, 99) < 70) ? nor4(a, b) : 4'($urandom));
            end
            run_queue(1'b0, 30, -1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_saturation();
        test_mid_reset();
        test_ignored();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
